// File: rtl/treg_pkg.sv
// Shared types and defaults for the T-register toggle controller.
// Optional feedback check is enabled with TREG_FB_CHECK_EN.
package treg_pkg;

    localparam int TREG_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_LOAD  = 2'b10
    } state_t;

    function automatic logic is_count_mode(input mode_t mode);
        return (mode == MODE_UP) || (mode == MODE_DOWN);
    endfunction

endpackage

// File: rtl/treg_toggle_ctrl_if.sv
// Load handshake, mode and T-register connections of treg_toggle_ctrl.
// ERR exists only when TREG_FB_CHECK_EN is defined.
interface treg_toggle_ctrl_if
    import treg_pkg::*;
#(
    parameter int WIDTH = TREG_WIDTH_DEFAULT
) ();

    logic [1:0]       MODE;
    logic             LOAD_VALID;
    logic [WIDTH-1:0] LOAD_DATA;
    logic             LOAD_READY;
    logic [WIDTH-1:0] Q_FB;
    logic [WIDTH-1:0] T_OUT;
    logic             WRAP;
    logic             BUSY;
`ifdef TREG_FB_CHECK_EN
    logic             ERR;
`endif

    modport master (
        output MODE, LOAD_VALID, LOAD_DATA, Q_FB,
        input  LOAD_READY, T_OUT, WRAP, BUSY
`ifdef TREG_FB_CHECK_EN
        , input ERR
`endif
    );

    modport slave (
        input  MODE, LOAD_VALID, LOAD_DATA, Q_FB,
        output LOAD_READY, T_OUT, WRAP, BUSY
`ifdef TREG_FB_CHECK_EN
        , output ERR
`endif
    );

endinterface

// File: rtl/treg_next_calc.sv
// Next count value and wrap flag for one up/down step modulo MODULUS.
// Arithmetic is carried in WIDTH+1 bits so shadow+STEP cannot overflow.
module treg_next_calc
    import treg_pkg::*;
#(
    parameter int WIDTH   = TREG_WIDTH_DEFAULT,
    parameter int MODULUS = 16,
    parameter int STEP    = 1
) (
    input  logic [WIDTH-1:0] i_shadow,
    input  mode_t            i_mode,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap
);

    localparam logic [WIDTH:0] L_MOD  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] L_STEP = (WIDTH+1)'(STEP);

    logic [WIDTH:0] w_ext;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_res;

    // Modular step in the direction selected by the registered mode
    always_comb begin
        w_ext  = {1'b0, i_shadow};
        w_sum  = w_ext + L_STEP;
        w_res  = w_ext;
        o_wrap = 1'b0;
        case (i_mode)
            MODE_UP: begin
                if (w_sum >= L_MOD) begin
                    w_res  = w_sum - L_MOD;
                    o_wrap = 1'b1;
                end else begin
                    w_res  = w_sum;
                end
            end
            MODE_DOWN: begin
                if (w_ext < L_STEP) begin
                    w_res  = w_ext + L_MOD - L_STEP;
                    o_wrap = 1'b1;
                end else begin
                    w_res  = w_ext - L_STEP;
                end
            end
            default: begin
                w_res  = w_ext;
            end
        endcase
        o_next = WIDTH'(w_res);
    end

endmodule

// File: rtl/treg_toggle_ctrl.sv
// Drives the T inputs of a WIDTH-bit T register: hold, count up/down modulo MODULUS, load.
// Define TREG_FB_CHECK_EN to compare Q_FB against the shadow and resync on mismatch (ERR).
module treg_toggle_ctrl
    import treg_pkg::*;
#(
    parameter int WIDTH   = TREG_WIDTH_DEFAULT,
    parameter int MODULUS = 16,
    parameter int STEP    = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    treg_toggle_ctrl_if.slave  bus
);

    localparam logic [WIDTH:0]   L_MOD     = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] L_MOD_MAX = WIDTH'(MODULUS - 1);

    state_t           r_state;
    state_t           w_state_next;
    mode_t            r_mode;
    mode_t            w_mode;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_ld;
    logic             r_ready;
    logic             r_busy;
    logic             r_wrap;
    logic             w_accept;
    logic [WIDTH-1:0] w_ld_clamped;
    logic [WIDTH-1:0] w_calc_next;
    logic             w_calc_wrap;
    logic [WIDTH-1:0] w_next_value;
    logic             w_wrap_set;

    assign w_mode   = mode_t'(bus.MODE);
    assign w_accept = bus.LOAD_VALID & r_ready;

    treg_next_calc #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .STEP    (STEP)
    ) u_next_calc (
        .i_shadow (r_shadow),
        .i_mode   (r_mode),
        .o_next   (w_calc_next),
        .o_wrap   (w_calc_wrap)
    );

    // Out-of-range load data is clamped to the top of the count range
    always_comb begin
        if ({1'b0, bus.LOAD_DATA} >= L_MOD) begin
            w_ld_clamped = L_MOD_MAX;
        end else begin
            w_ld_clamped = bus.LOAD_DATA;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: an accepted load beats a counting mode
    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE, ST_COUNT: begin
                if (w_accept) begin
                    w_state_next = ST_LOAD;
                end else if (is_count_mode(w_mode)) begin
                    w_state_next = ST_COUNT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (is_count_mode(w_mode)) begin
                    w_state_next = ST_COUNT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: the value the register will hold after this edge
    always_comb begin
        w_next_value = r_shadow;
        w_wrap_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_value = r_shadow;
            end
            ST_COUNT: begin
                // A load accepted mid-count suppresses this cycle's step (T_OUT=0)
                if (w_accept) begin
                    w_next_value = r_shadow;
                end else begin
                    w_next_value = w_calc_next;
                    w_wrap_set   = w_calc_wrap;
                end
            end
            ST_LOAD: begin
                w_next_value = r_ld;
            end
            default: begin
                w_next_value = r_shadow;
            end
        endcase
    end

`ifdef TREG_FB_CHECK_EN
    logic r_err;
    logic w_fb_mismatch;
    assign w_fb_mismatch = (bus.Q_FB != r_shadow);
    assign bus.ERR       = r_err;
`else
    logic w_unused_qfb;
    assign w_unused_qfb = ^bus.Q_FB;
`endif

    // Shadow, captured load value and registered status outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_mode   <= MODE_HOLD;
            r_shadow <= {WIDTH{1'b0}};
            r_ld     <= {WIDTH{1'b0}};
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_wrap   <= 1'b0;
`ifdef TREG_FB_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_mode  <= w_mode;
            r_ready <= (w_state_next != ST_LOAD);
            r_busy  <= (w_state_next == ST_LOAD);
            if (w_accept) begin
                r_ld <= w_ld_clamped;
            end else begin
                r_ld <= r_ld;
            end
`ifdef TREG_FB_CHECK_EN
            if (w_fb_mismatch) begin
                r_shadow <= bus.Q_FB;
                r_err    <= 1'b1;
                r_wrap   <= 1'b0;
            end else begin
                r_shadow <= w_next_value;
                r_err    <= 1'b0;
                r_wrap   <= w_wrap_set;
            end
`else
            r_shadow <= w_next_value;
            r_wrap   <= w_wrap_set;
`endif
        end
    end

    assign bus.T_OUT      = r_shadow ^ w_next_value;
    assign bus.LOAD_READY = r_ready;
    assign bus.BUSY       = r_busy;
    assign bus.WRAP       = r_wrap;

endmodule

// File: tb/tb_treg_toggle_ctrl.sv
// Directed bench for treg_toggle_ctrl: one instance with MODULUS=16, one with MODULUS=10,
// each driving a behavioural T register. The ERR scenario runs when TREG_FB_CHECK_EN is defined.
module tb_treg_toggle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] q_a;
    logic [3:0] q_b;
    logic       force_a;
    logic [3:0] force_val;
    int         checks;
    int         failures;

    treg_toggle_ctrl_if #(.WIDTH(4)) bus_a ();
    treg_toggle_ctrl_if #(.WIDTH(4)) bus_b ();

    treg_toggle_ctrl #(.WIDTH(4), .MODULUS(16), .STEP(1)) dut_a (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus_a)
    );

    treg_toggle_ctrl #(.WIDTH(4), .MODULUS(10), .STEP(1)) dut_b (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_a.Q_FB = force_a ? force_val : q_a;
    assign bus_b.Q_FB = q_b;

    // Behavioural T registers; force_a models an upset that overwrites register A
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a <= 4'h0;
            q_b <= 4'h0;
        end else begin
            q_a <= force_a ? force_val : (q_a ^ bus_a.T_OUT);
            q_b <= q_b ^ bus_b.T_OUT;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks += 5;
        if (bus_a.T_OUT !== 4'h0) begin failures++; $display("FAIL rst_tout got=%0d exp=0", bus_a.T_OUT); end
        if (bus_a.WRAP !== 1'b0) begin failures++; $display("FAIL rst_wrap got=%0b exp=0", bus_a.WRAP); end
        if (bus_a.BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus_a.BUSY); end
        if (bus_a.LOAD_READY !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", bus_a.LOAD_READY); end
        if (bus_b.LOAD_READY !== 1'b0) begin failures++; $display("FAIL rst_ready_b got=%0b exp=0", bus_b.LOAD_READY); end
`ifdef TREG_FB_CHECK_EN
        checks++;
        if (bus_a.ERR !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", bus_a.ERR); end
`endif
        rst_n = 1'b1;
        tick();
        checks += 2;
        if (bus_a.LOAD_READY !== 1'b1) begin failures++; $display("FAIL rel_ready got=%0b exp=1", bus_a.LOAD_READY); end
        if (bus_a.T_OUT !== 4'h0) begin failures++; $display("FAIL rel_tout got=%0d exp=0", bus_a.T_OUT); end
    endtask

    task automatic test_count_up();
        logic [3:0] exp_q;
        logic [3:0] exp_t;
        logic       exp_w;
        bus_a.MODE = 2'b01;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_q = 4'(i % 16);
            exp_t = exp_q ^ 4'((i + 1) % 16);
            exp_w = (i == 16);
            checks += 3;
            if (q_a !== exp_q) begin failures++; $display("FAIL up_q[%0d] got=%0d exp=%0d", i, q_a, exp_q); end
            if (bus_a.T_OUT !== exp_t) begin failures++; $display("FAIL up_tout[%0d] got=%0d exp=%0d", i, bus_a.T_OUT, exp_t); end
            if (bus_a.WRAP !== exp_w) begin failures++; $display("FAIL up_wrap[%0d] got=%0b exp=%0b", i, bus_a.WRAP, exp_w); end
        end
        bus_a.MODE = 2'b00;
        tick();
        checks += 2;
        if (q_a !== 4'd4) begin failures++; $display("FAIL up_stop_q got=%0d exp=4", q_a); end
        if (bus_a.T_OUT !== 4'h0) begin failures++; $display("FAIL up_stop_tout got=%0d exp=0", bus_a.T_OUT); end
    endtask

    task automatic test_count_down();
        logic [3:0] exp_q;
        logic [3:0] exp_t;
        logic       exp_w;
        bus_b.MODE = 2'b10;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_q = 4'((10 - (i % 10)) % 10);
            exp_t = exp_q ^ 4'((int'(exp_q) + 9) % 10);
            exp_w = (i == 1) || (i == 11);
            checks += 3;
            if (q_b !== exp_q) begin failures++; $display("FAIL dn_q[%0d] got=%0d exp=%0d", i, q_b, exp_q); end
            if (bus_b.T_OUT !== exp_t) begin failures++; $display("FAIL dn_tout[%0d] got=%0d exp=%0d", i, bus_b.T_OUT, exp_t); end
            if (bus_b.WRAP !== exp_w) begin failures++; $display("FAIL dn_wrap[%0d] got=%0b exp=%0b", i, bus_b.WRAP, exp_w); end
        end
        bus_b.MODE = 2'b00;
        tick();
        checks += 2;
        if (q_b !== 4'd8) begin failures++; $display("FAIL dn_stop_q got=%0d exp=8", q_b); end
        if (bus_b.T_OUT !== 4'h0) begin failures++; $display("FAIL dn_stop_tout got=%0d exp=0", bus_b.T_OUT); end
    endtask

    task automatic test_load();
        bus_a.MODE = 2'b01;
        tick();
        bus_a.MODE = 2'b00;
        tick();
        checks++;
        if (q_a !== 4'd5) begin failures++; $display("FAIL ld_pre_q got=%0d exp=5", q_a); end
        bus_a.LOAD_DATA  = 4'd12;
        bus_a.LOAD_VALID = 1'b1;
        #1;
        checks++;
        if (bus_a.LOAD_READY !== 1'b1) begin failures++; $display("FAIL ld_ready got=%0b exp=1", bus_a.LOAD_READY); end
        tick();
        bus_a.LOAD_VALID = 1'b0;
        checks += 3;
        if (bus_a.BUSY !== 1'b1) begin failures++; $display("FAIL ld_busy got=%0b exp=1", bus_a.BUSY); end
        if (bus_a.LOAD_READY !== 1'b0) begin failures++; $display("FAIL ld_busy_ready got=%0b exp=0", bus_a.LOAD_READY); end
        if (bus_a.T_OUT !== 4'd9) begin failures++; $display("FAIL ld_tout got=%0d exp=9", bus_a.T_OUT); end
        tick();
        checks += 3;
        if (q_a !== 4'd12) begin failures++; $display("FAIL ld_q got=%0d exp=12", q_a); end
        if (bus_a.BUSY !== 1'b0) begin failures++; $display("FAIL ld_done_busy got=%0b exp=0", bus_a.BUSY); end
        if (bus_a.LOAD_READY !== 1'b1) begin failures++; $display("FAIL ld_done_ready got=%0b exp=1", bus_a.LOAD_READY); end
        // reloading the current value still costs a LOAD cycle with a zero mask
        bus_a.LOAD_VALID = 1'b1;
        tick();
        bus_a.LOAD_VALID = 1'b0;
        checks += 2;
        if (bus_a.BUSY !== 1'b1) begin failures++; $display("FAIL ld_same_busy got=%0b exp=1", bus_a.BUSY); end
        if (bus_a.T_OUT !== 4'h0) begin failures++; $display("FAIL ld_same_tout got=%0d exp=0", bus_a.T_OUT); end
        tick();
        checks++;
        if (q_a !== 4'd12) begin failures++; $display("FAIL ld_same_q got=%0d exp=12", q_a); end
    endtask

    task automatic test_load_clamp();
        bus_b.LOAD_DATA  = 4'd15;
        bus_b.LOAD_VALID = 1'b1;
        tick();
        bus_b.LOAD_VALID = 1'b0;
        checks += 2;
        if (bus_b.BUSY !== 1'b1) begin failures++; $display("FAIL clamp_busy got=%0b exp=1", bus_b.BUSY); end
        if (bus_b.T_OUT !== 4'd1) begin failures++; $display("FAIL clamp_tout got=%0d exp=1", bus_b.T_OUT); end
        tick();
        checks++;
        if (q_b !== 4'd9) begin failures++; $display("FAIL clamp_q got=%0d exp=9", q_b); end
    endtask

    task automatic test_load_vs_count();
        bus_a.MODE       = 2'b01;
        bus_a.LOAD_DATA  = 4'd3;
        bus_a.LOAD_VALID = 1'b1;
        tick();
        bus_a.LOAD_VALID = 1'b0;
        checks += 3;
        if (bus_a.BUSY !== 1'b1) begin failures++; $display("FAIL lc_busy got=%0b exp=1", bus_a.BUSY); end
        if (q_a !== 4'd12) begin failures++; $display("FAIL lc_nostep got=%0d exp=12", q_a); end
        if (bus_a.T_OUT !== 4'd15) begin failures++; $display("FAIL lc_tout got=%0d exp=15", bus_a.T_OUT); end
        tick();
        checks += 2;
        if (q_a !== 4'd3) begin failures++; $display("FAIL lc_q3 got=%0d exp=3", q_a); end
        if (bus_a.T_OUT !== 4'd7) begin failures++; $display("FAIL lc_tout3 got=%0d exp=7", bus_a.T_OUT); end
        tick();
        tick();
        checks++;
        if (q_a !== 4'd5) begin failures++; $display("FAIL lc_q5 got=%0d exp=5", q_a); end
        // load arriving while already counting
        bus_a.LOAD_DATA  = 4'd10;
        bus_a.LOAD_VALID = 1'b1;
        #1;
        checks++;
        if (bus_a.T_OUT !== 4'h0) begin failures++; $display("FAIL cl_tout got=%0d exp=0", bus_a.T_OUT); end
        tick();
        bus_a.LOAD_VALID = 1'b0;
        checks += 2;
        if (q_a !== 4'd5) begin failures++; $display("FAIL cl_nostep got=%0d exp=5", q_a); end
        if (bus_a.T_OUT !== 4'd15) begin failures++; $display("FAIL cl_ld_tout got=%0d exp=15", bus_a.T_OUT); end
        tick();
        checks++;
        if (q_a !== 4'd10) begin failures++; $display("FAIL cl_q got=%0d exp=10", q_a); end
        bus_a.MODE = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_load();
        bus_a.LOAD_DATA  = 4'd7;
        bus_a.LOAD_VALID = 1'b1;
        tick();
        bus_a.LOAD_VALID = 1'b0;
        checks++;
        if (bus_a.BUSY !== 1'b1) begin failures++; $display("FAIL rml_busy got=%0b exp=1", bus_a.BUSY); end
        #1;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus_a.T_OUT !== 4'h0) begin failures++; $display("FAIL rml_tout got=%0d exp=0", bus_a.T_OUT); end
        if (bus_a.BUSY !== 1'b0) begin failures++; $display("FAIL rml_busy0 got=%0b exp=0", bus_a.BUSY); end
        if (bus_a.LOAD_READY !== 1'b0) begin failures++; $display("FAIL rml_ready got=%0b exp=0", bus_a.LOAD_READY); end
        if (bus_a.WRAP !== 1'b0) begin failures++; $display("FAIL rml_wrap got=%0b exp=0", bus_a.WRAP); end
        tick();
        rst_n = 1'b1;
        tick();
        checks += 2;
        if (bus_a.LOAD_READY !== 1'b1) begin failures++; $display("FAIL rml_rel_ready got=%0b exp=1", bus_a.LOAD_READY); end
        if (bus_a.WRAP !== 1'b0) begin failures++; $display("FAIL rml_rel_wrap got=%0b exp=0", bus_a.WRAP); end
        bus_a.MODE = 2'b01;
        tick();
        checks += 2;
        if (q_a !== 4'd0) begin failures++; $display("FAIL rml_q got=%0d exp=0", q_a); end
        if (bus_a.T_OUT !== 4'd1) begin failures++; $display("FAIL rml_cnt_tout got=%0d exp=1", bus_a.T_OUT); end
        bus_a.MODE = 2'b00;
        tick();
    endtask

`ifdef TREG_FB_CHECK_EN
    task automatic test_fb_check();
        bus_a.MODE = 2'b01;
        tick();
        tick();
        checks += 2;
        if (q_a !== 4'd2) begin failures++; $display("FAIL fb_pre_q got=%0d exp=2", q_a); end
        if (bus_a.ERR !== 1'b0) begin failures++; $display("FAIL fb_pre_err got=%0b exp=0", bus_a.ERR); end
        force_val = 4'd6;
        force_a   = 1'b1;
        tick();
        force_a   = 1'b0;
        checks += 2;
        if (bus_a.ERR !== 1'b1) begin failures++; $display("FAIL fb_err got=%0b exp=1", bus_a.ERR); end
        if (bus_a.T_OUT !== 4'd1) begin failures++; $display("FAIL fb_tout got=%0d exp=1", bus_a.T_OUT); end
        tick();
        checks += 3;
        if (bus_a.ERR !== 1'b0) begin failures++; $display("FAIL fb_err_clr got=%0b exp=0", bus_a.ERR); end
        if (q_a !== 4'd7) begin failures++; $display("FAIL fb_q got=%0d exp=7", q_a); end
        if (bus_a.T_OUT !== 4'd15) begin failures++; $display("FAIL fb_tout7 got=%0d exp=15", bus_a.T_OUT); end
        bus_a.MODE = 2'b00;
        tick();
    endtask
`endif

    initial begin
        checks           = 0;
        failures         = 0;
        force_a          = 1'b0;
        force_val        = 4'h0;
        rst_n            = 1'b0;
        bus_a.MODE       = 2'b00;
        bus_a.LOAD_VALID = 1'b0;
        bus_a.LOAD_DATA  = 4'h0;
        bus_b.MODE       = 2'b00;
        bus_b.LOAD_VALID = 1'b0;
        bus_b.LOAD_DATA  = 4'h0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_load_clamp();
        test_load_vs_count();
        test_reset_mid_load();
`ifdef TREG_FB_CHECK_EN
        test_fb_check();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
